rtds_tx_framer: RTL and testbench
=================================

Name: rtds_tx_framer

Overview:
- Transmit-side framer for the Aurora 8b10b link to RTDS.
- Holds one outgoing frame in a local word buffer that is written through a simple write port.
- On a trigger pulse (e.g. generated after the last word of a received RTDS frame), streams the frame as an AXI-Stream master toward the Aurora TX user interface, with `tlast` on the final word.
- Counts sent packets and dropped triggers as status, mirroring the RX packet counter.

Parameters:
- DATA_WIDTH, 32, width of buffer words and `m_axis_tdata`.
- ADDR_WIDTH, 6, buffer address width; buffer depth MAX_WORDS = 2**ADDR_WIDTH (64).
- IFG_CYCLES, 4, idle cycles enforced after each frame before a new trigger is accepted; 0 = no gap.

Ports:
- m_axis_aclk  in  1  single clock (Aurora `user_clk_out` domain).
- m_axis_aresetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_WIDTH  buffer write address.
- wr_data  in  DATA_WIDTH  buffer write data.
- ctrl_num_words  in  ADDR_WIDTH+1  frame length in words; sampled on trigger acceptance.
- tx_trigger  in  1  start request; level sampled each cycle, one frame per accepted high cycle.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tdata  out  DATA_WIDTH  AXI-Stream data.
- m_axis_tlast  out  1  AXI-Stream last.
- m_axis_tready  in  1  AXI-Stream ready (Aurora TX backpressure).
- busy  out  1  high in SEND or GAP state.
- stat_cnt_pkts_out  out  32  frames completed since reset.
- stat_cnt_trig_drop  out  16  triggers ignored since reset.

Behaviour:
- Reset: all registers clear asynchronously on `m_axis_aresetn` low.
  - `tvalid`, `tlast`, `tdata`, `busy` and both counters go to 0; state goes to IDLE.
  - Buffer contents are not reset and are retained.
  - Reset asserted mid-frame: `tvalid` drops immediately, the frame is abandoned and not counted.
- Buffer: when `wr_en` is high at a clock edge, `mem[wr_addr]` is written with `wr_data`. Reads are asynchronous.
  - A write to a word index greater than the one currently presented takes effect in the current frame. No frame atomicity.
  - A write to the presented word does not alter the registered `tdata`.
- Length: on acceptance, `len = ctrl_num_words`; if `len > MAX_WORDS` it is clamped to MAX_WORDS.
- IDLE:
  - `tx_trigger` high with `len == 0`: trigger ignored, `stat_cnt_trig_drop` increments.
  - `tx_trigger` high with `len >= 1`, at edge T: capture `len`, set `rd_ptr = 1`, `tdata <= mem[0]`, `tvalid <= 1`, `tlast <= (len == 1)`, go to SEND.
  - Word 0 is therefore visible in the cycle after the trigger edge (latency 1).
- SEND: handshake = `tvalid & tready`.
  - Non-final word handshake: `tdata <= mem[rd_ptr]`, `rd_ptr++`, `tlast <= (rd_ptr == len-1)`.
  - `tready` low: `tdata`, `tlast` and `tvalid` hold stable. `tvalid` is never withdrawn before its handshake.
  - Handshake with `tlast == 1`: `tvalid <= 0`, `tlast <= 0`, `stat_cnt_pkts_out++` (wraps modulo 2^32), gap counter loaded with IFG_CYCLES.
    - Next state is GAP, or IDLE directly when IFG_CYCLES == 0.
- GAP: decrement the counter each cycle; enter IDLE after exactly IFG_CYCLES cycles with `tvalid` low.
- Trigger in SEND or GAP: not queued; `stat_cnt_trig_drop` increments once per high cycle. This includes the cycle of the final handshake.
- `stat_cnt_trig_drop` saturates at 16'hFFFF.
- Back-to-back frames: a trigger held high is re-accepted on the first IDLE cycle.
- `busy` is combinational from state.

Test Plan:
1. Write `mem[0..2] = 0xA0, 0xA1, 0xA2`, `ctrl_num_words = 3`, `tready` always 1, one-cycle trigger:
   - `tvalid` is high the next cycle with A0, A1, A2 on three consecutive cycles, `tlast` only with A2.
   - `stat_cnt_pkts_out = 1`.
   - `busy` stays high for IFG_CYCLES (4) cycles after `tlast`.
2. Same frame with `tready` toggled 1,0,0,1,0,1:
   - Data holds while `tready` is low; exactly 3 handshakes in order A0, A1, A2.
   - `tvalid` never drops mid-frame.
3. `ctrl_num_words = 1`, trigger:
   - Single beat with `tlast = 1` and `tdata = mem[0]`.
   - Then `ctrl_num_words = 0`, trigger: no `tvalid`, `stat_cnt_trig_drop = 1`.
4. `ctrl_num_words = 100`: 64 beats, `tlast` on beat 64 carrying `mem[63]`.
   - Trigger pulses on 3 cycles during SEND and 1 during GAP: `stat_cnt_trig_drop = 4`, no extra frames.
5. Assert `m_axis_aresetn` low after 2 handshakes of a 5-word frame:
   - `tvalid` and both counters are 0 immediately.
   - A trigger after release sends all 5 words from `mem[0]`, with buffer contents unchanged.
6. Write `mem[3] = 0x55` while word 1 of a 4-word frame is stalled with `tready = 0`: the frame emits 0x55 as its last word.
   - Hold `tx_trigger` high continuously: frames repeat every 4 + IFG_CYCLES + 1 cycles with `tready = 1`, and `stat_cnt_pkts_out` increments each frame.

Source files
------------

// File: rtl/rtds_tx_framer.sv
// Transmit framer for the Aurora link to RTDS: a local frame buffer that is
// streamed out as an AXI-Stream master on each accepted trigger.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a trigger with a non-zero frame length
// SEND  | presenting buffer words on m_axis, advancing on each handshake
// GAP   | inter-frame idle, down-counting IFG_CYCLES before the next trigger
module rtds_tx_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int IFG_CYCLES = 4
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   ctrl_num_words,
  input  logic                  tx_trigger,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic [31:0]           stat_cnt_pkts_out,
  output logic [15:0]           stat_cnt_trig_drop
);

  localparam int MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam int GAP_W = $clog2(IFG_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_WIDTH-1:0] mem [MAX_WORDS];
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [GAP_W-1:0]      gap_cnt;
  logic [ADDR_WIDTH:0]   num_clamped;
  logic                  trig_dropped;

  // Buffer is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge m_axis_aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign num_clamped  = (ctrl_num_words > MAX_LEN) ? MAX_LEN : ctrl_num_words;
  assign trig_dropped = tx_trigger && ((state != IDLE) || (num_clamped == '0));
  assign busy         = (state != IDLE);

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state              <= IDLE;
      len                <= '0;
      rd_ptr             <= '0;
      gap_cnt            <= '0;
      m_axis_tvalid      <= 1'b0;
      m_axis_tdata       <= '0;
      m_axis_tlast       <= 1'b0;
      stat_cnt_pkts_out  <= '0;
      stat_cnt_trig_drop <= '0;
    end else begin
      if (trig_dropped && (stat_cnt_trig_drop != 16'hFFFF))
        stat_cnt_trig_drop <= stat_cnt_trig_drop + 16'd1;

      case (state)
        IDLE: begin
          if (tx_trigger && (num_clamped != '0)) begin
            len           <= num_clamped;
            rd_ptr        <= {{ADDR_WIDTH{1'b0}}, 1'b1};
            m_axis_tdata  <= mem[0];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (num_clamped == {{ADDR_WIDTH{1'b0}}, 1'b1});
            state         <= SEND;
          end
        end

        SEND: begin
          if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
              m_axis_tvalid     <= 1'b0;
              m_axis_tlast      <= 1'b0;
              stat_cnt_pkts_out <= stat_cnt_pkts_out + 32'd1;
              gap_cnt           <= GAP_W'(IFG_CYCLES);
              state             <= (IFG_CYCLES == 0) ? IDLE : GAP;
            end else begin
              // Asynchronous read here lets late writes to upcoming words land in this frame.
              m_axis_tdata <= mem[rd_ptr[ADDR_WIDTH-1:0]];
              rd_ptr       <= rd_ptr + 1'b1;
              m_axis_tlast <= (rd_ptr == (len - 1'b1));
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
          else                      gap_cnt <= gap_cnt - 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtds_tx_framer.sv
// Scoreboard bench for rtds_tx_framer: expected beats are queued when a frame
// is triggered and compared as handshakes occur.
module tb_rtds_tx_framer;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int IFG = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   ctrl_num_words;
  logic          tx_trigger;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;
  logic          busy;
  logic [31:0]   cnt_pkts;
  logic [15:0]   cnt_drop;

  rtds_tx_framer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IFG_CYCLES(IFG)) dut (
    .m_axis_aclk        (clk),
    .m_axis_aresetn     (rst_n),
    .wr_en              (wr_en),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .ctrl_num_words     (ctrl_num_words),
    .tx_trigger         (tx_trigger),
    .m_axis_tvalid      (tvalid),
    .m_axis_tdata       (tdata),
    .m_axis_tlast       (tlast),
    .m_axis_tready      (tready),
    .busy               (busy),
    .stat_cnt_pkts_out  (cnt_pkts),
    .stat_cnt_trig_drop (cnt_drop)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];
  logic [DW-1:0] sm [64];
  int          exp_pkts;
  int          exp_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    sm[a]   = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic push_frame(input int n);
    int m;
    m = (n > 64) ? 64 : n;
    for (int i = 0; i < m; i++)
      exp_q.push_back({31'b0, (i == m - 1), sm[i]});
  endtask

  task automatic pulse_trig(input int n);
    ctrl_num_words = (AW + 1)'(n);
    tx_trigger     = 1'b1;
    step();
    tx_trigger     = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      step();
      k++;
    end
    chk("idle_wait", {63'b0, busy}, 64'd0);
  endtask

  task automatic wait_drained();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 2000) begin
      step();
      k++;
    end
    chk("drain_q", 64'(exp_q.size()), 64'd0);
  endtask

  // Beat monitor: compares handshakes against the queue and checks stall stability.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {63'b0, tvalid}, 64'd1);
        chk("hold_data", {32'b0, tdata}, {32'b0, prev_data});
        chk("hold_last", {63'b0, tlast}, {63'b0, prev_last});
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) chk("extra_beat", {31'b0, tlast, tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        else                   chk("beat", {31'b0, tlast, tdata}, exp_q.pop_front());
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  initial begin
    logic [1:0] rdy_pat [6];
    int d;
    rdy_pat = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 64; i++) sm[i] = '0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ctrl_num_words = '0; tx_trigger = 1'b0; tready = 1'b1;
    exp_pkts = 0; exp_drop = 0;
    #2;
    chk("rst_tvalid", {63'b0, tvalid}, 64'd0);
    chk("rst_tlast", {63'b0, tlast}, 64'd0);
    chk("rst_tdata", {32'b0, tdata}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_pkts", {32'b0, cnt_pkts}, 64'd0);
    chk("rst_drop", {48'b0, cnt_drop}, 64'd0);
    step(2);
    rst_n = 1'b1;
    step();

    // 1: basic 3-word frame, latency and inter-frame gap
    wr(0, 32'hA0); wr(1, 32'hA1); wr(2, 32'hA2);
    push_frame(3);
    pulse_trig(3);
    chk("t1_latency", {63'b0, tvalid}, 64'd1);
    step(3);
    exp_pkts++;
    chk("t1_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));
    chk("t1_tvalid_off", {63'b0, tvalid}, 64'd0);
    for (int i = 0; i < IFG; i++) begin
      chk("t1_gap_busy", {63'b0, busy}, 64'd1);
      step();
    end
    chk("t1_gap_end", {63'b0, busy}, 64'd0);

    // 2: same frame under backpressure
    push_frame(3);
    ctrl_num_words = 7'd3;
    tx_trigger = 1'b1;
    step();
    tx_trigger = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tready = rdy_pat[i][0];
      step();
    end
    tready = 1'b1;
    wait_drained();
    exp_pkts++;
    chk("t2_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));

    // 3: single-word frame, then zero-length trigger is dropped
    push_frame(1);
    pulse_trig(1);
    wait_drained();
    exp_pkts++;
    chk("t3_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));
    pulse_trig(0);
    exp_drop++;
    chk("t3_no_valid", {63'b0, tvalid}, 64'd0);
    chk("t3_drop", {48'b0, cnt_drop}, 64'(exp_drop));

    // 4: over-length request clamps to 64 words; triggers while busy are dropped
    for (int i = 0; i < 64; i++) wr(i, 32'hC0DE_0000 | i);
    push_frame(100);
    pulse_trig(100);
    step(5);  tx_trigger = 1'b1; step(); tx_trigger = 1'b0;
    step(10); tx_trigger = 1'b1; step(); tx_trigger = 1'b0;
    step(20); tx_trigger = 1'b1; step(); tx_trigger = 1'b0;
    exp_drop += 3;
    d = 0;
    while (!(busy && !tvalid) && d < 200) begin
      step();
      d++;
    end
    chk("t4_in_gap", {62'b0, busy, tvalid}, 64'd2);
    tx_trigger = 1'b1; step(); tx_trigger = 1'b0;
    exp_drop++;
    wait_drained();
    exp_pkts++;
    step(10);
    chk("t4_no_extra", {63'b0, tvalid}, 64'd0);
    chk("t4_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));
    chk("t4_drop", {48'b0, cnt_drop}, 64'(exp_drop));

    // 5: reset after two handshakes of a 5-word frame
    push_frame(5);
    pulse_trig(5);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {63'b0, tvalid}, 64'd0);
    chk("t5_rst_pkts", {32'b0, cnt_pkts}, 64'd0);
    chk("t5_rst_drop", {48'b0, cnt_drop}, 64'd0);
    exp_q.delete();
    exp_pkts = 0;
    exp_drop = 0;
    step(2);
    rst_n = 1'b1;
    step();
    push_frame(5);
    pulse_trig(5);
    wait_drained();
    exp_pkts++;
    chk("t5_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));

    // 6: late write to an upcoming word during a stall
    sm[3] = 32'h55;
    push_frame(4);
    pulse_trig(4);
    step();
    tready = 1'b0;
    wr(3, 32'h55);
    step();
    tready = 1'b1;
    wait_drained();
    exp_pkts++;
    chk("t6_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));

    // 6b: trigger held high gives back-to-back frames every 4 + IFG + 1 cycles
    wait_idle();
    push_frame(4); push_frame(4); push_frame(4);
    ctrl_num_words = 7'd4;
    tx_trigger = 1'b1;
    for (d = 0; d < 27; d++) begin
      step();
      if (d >= 1 && d <= 18 && ((d - 1) % 9) <= 7) exp_drop++;
      if (d == 4 || d == 13 || d == 22) exp_pkts++;
      chk("t6_rep_valid", {63'b0, tvalid}, ((d % 9) < 4) ? 64'd1 : 64'd0);
      chk("t6_rep_pkts", {32'b0, cnt_pkts}, 64'(exp_pkts));
      chk("t6_rep_drop", {48'b0, cnt_drop}, 64'(exp_drop));
      if (d == 18) tx_trigger = 1'b0;
    end
    wait_drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
